// File: rtl/rev_add_sequencer.sv
// 16-bit add/subtract built from one 4-bit reversible adder slice, reused over
// four nibbles (LSB first) with a sticky check that the slice's pass-through outputs match its inputs.

module RevAdder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic [3:0] aout_o,
  output logic [3:0] bout_o,
  output logic       cinv_o
);

  logic [4:0] carry;

  // B and Cin are reconstructed from the sum and ripple carries rather than
  // wired straight through, so the check really exercises the inverse path.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    bout_o   = '0;
    carry[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    for (int i = 0; i < 4; i++) begin
      bout_o[i] = sum_o[i] ^ a_i[i] ^ carry[i];
    end
  end

  assign aout_o = a_i;
  assign cout_o = carry[4];
  assign cinv_o = sum_o[0] ^ a_i[0] ^ b_i[0];

endmodule

module rev_add_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        ovf,
  output logic        rev_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] beff_q, beff_d;
  logic        carry_q, carry_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;

  logic [3:0]  aNib, bNib;
  logic [3:0]  sliceSum, sliceAout, sliceBout;
  logic        sliceCout, sliceCinv;

  assign aNib = a_q[{idx_q, 2'b00} +: 4];
  assign bNib = beff_q[{idx_q, 2'b00} +: 4];

  RevAdder u_slice (
    .a_i    (aNib),
    .b_i    (bNib),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout),
    .aout_o (sliceAout),
    .bout_o (sliceBout),
    .cinv_o (sliceCinv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      beff_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    beff_d  = beff_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = A;
          beff_d  = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = sliceSum;
        carry_d = sliceCout;
        err_d   = err_q | (sliceAout != aNib) | (sliceBout != bNib) |
                  (sliceCinv != carry_q);
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = HOLD;
          cout_d  = sliceCout;
          ovf_d   = (a_q[15] == beff_q[15]) && (sliceSum[3] != a_q[15]);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign ovf       = ovf_q;
  assign rev_err   = err_q;

endmodule

// File: tb/tb_rev_add_sequencer.sv
// Scoreboard bench for rev_add_sequencer: the driver queues hand-computed results,
// a negedge monitor pops and compares them on every output handshake.

module tb_rev_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Sum;
  logic        Cout;
  logic        ovf;
  logic        rev_err;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sbQ[$];

  rev_add_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .ovf       (ovf),
    .rev_err   (rev_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("Sum", {16'd0, Sum}, {16'd0, e.sum});
        checkOutput("Cout", {31'd0, Cout}, {31'd0, e.cout});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        checkOutput("rev_err", {31'd0, rev_err}, {31'd0, e.err});
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                               input logic s, input exp_t e);
    int n;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF;
  endtask

  // Counts edges from acceptance until out_valid; optionally corrupts the slice's
  // B pass-through while nibble 1 is being processed.
  task automatic waitResult(input bit injectFault, input exp_t e);
    int n;
    bit seen;
    seen = 0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (injectFault && n == 1) force dut.sliceBout = 4'h3;
      if (injectFault && n == 2) release dut.sliceBout;
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    checkOutput("latency", n, 4);
    if (!seen) return;
    if (out_ready) begin
      @(negedge clk);
      checkOutput("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      checkOutput("Sum_retained_idle", {16'd0, Sum}, {16'd0, e.sum});
    end
  endtask

  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s, input logic [15:0] es, input logic ec,
                       input logic eo, input logic ee, input bit fault);
    exp_t e;
    e = '{sum: es, cout: ec, ovf: eo, err: ee};
    applyStimulus(a, b, c, s, e);
    waitResult(fault, e);
  endtask

  initial begin
    exp_t e;
    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_Sum", {16'd0, Sum}, 32'd0);
    checkOutput("rst_Cout", {31'd0, Cout}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("rst_rev_err", {31'd0, rev_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    runOp(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
    runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    runOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    runOp(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
    runOp(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 0);
    runOp(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 0);

    // Back-pressure: result must hold and no second operation may be captured.
    out_ready = 1'b0;
    e = '{sum: 16'hB6B7, cout: 1'b0, ovf: 1'b0, err: 1'b0};
    applyStimulus(16'hA5A5, 16'h1111, 1'b1, 1'b0, e);
    waitResult(0, e);
    in_valid = 1'b1; A = 16'h0101; B = 16'h0101;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_Sum", {16'd0, Sum}, 32'h0000B6B7);
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hs_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_second_capture", {31'd0, out_valid}, 32'd0);
    end
    checkOutput("Sum_after_hold", {16'd0, Sum}, 32'h0000B6B7);

    // Reset during RUN abandons the operation.
    e = '{sum: 16'h2345, cout: 1'b0, ovf: 1'b0, err: 1'b0};
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, e);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrun_rst_Sum", {16'd0, Sum}, 32'd0);
    void'(sbQ.pop_back());
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrun_rst_Sum_after", {16'd0, Sum}, 32'd0);
    runOp(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

    // Corrupted reversibility path sets rev_err but not the sum.
    runOp(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1, 1);
    runOp(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
